conv_8_32: RTL
==============

Name: conv_8_32

Overview:
- Byte-to-word assembler: the receive end of the 32-bit to 8-bit serializer link.
- Collects four consecutive valid bytes from the 8-bit stream and presents them as one 32-bit word with a valid/ready handshake.
- Single clock domain.
- Holds one assembled word while the output stalls, and applies backpressure upstream only when both stages are full.
- A partial word that stalls too long is discarded and flagged.

Parameters:
- MSB_FIRST, 1: 1 = first byte of a word lands in [31:24]; 0 = first byte lands in [7:0].
- TIMEOUT, 16: idle cycles allowed inside a partial word before it is discarded. 0 disables the timeout.
- TO_W, 5: width of the idle counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-low: 0 = in reset.
- in_data8  input  8  byte from the serializer.
- in8  input  1  in_data8 is valid this cycle.
- in_ready  output  1  the assembler accepts a byte this cycle.
- out_data32  output  32  assembled word.
- out32  output  1  out_data32 is valid.
- out_ready  input  1  downstream consumes out_data32 this cycle.
- byte_cnt  output  2  bytes held in the partial word (0-3).
- err_timeout  output  1  one-cycle pulse when a partial word is discarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_data32=0, out32=0, byte_cnt=0, err_timeout=0, idle counter=0, assembly register=0.
  - in_ready goes to 1 once reset=1.
  - Asserting reset mid-word or mid-stall discards everything; no partial word is output.
- Byte accept: a byte is accepted when in8 && in_ready at a rising edge. Bytes are never accepted otherwise.
- Byte placement: with MSB_FIRST=1, the byte at byte_cnt=k goes to bits [31-8k -: 8]; with MSB_FIRST=0 it goes to [8k +: 8].
- byte_cnt increments on each accept and wraps 3 -> 0 on the 4th byte.
- Gaps (in8=0) between bytes of a word are legal; the partial word is held.
- Word completion (4th byte accepted at edge N):
  - Output empty (out32=0), or output being consumed at edge N (out_ready=1): word loads into out_data32 at edge N, out32=1 from N onward.
  - Latency: 4th byte to out32 is one edge.
  - Otherwise: state goes ASSEMBLE -> HOLD. The word stays in the assembly register and in_ready=0.
- State machine:
  - ASSEMBLE: in_ready=1.
  - HOLD: in_ready=0. On the first edge with out_ready=1 (output consumed), the held word moves to the output register (out32 stays 1) and state returns to ASSEMBLE with byte_cnt=0.
- Output register:
  - out32 clears on an edge with out_ready=1 and no new load.
  - Simultaneous consume and load keeps out32=1 with the new data; no bubble.
  - out_data32 is unchanged while out32=1 && out_ready=0.
  - out_data32 keeps its last value after consumption.
- Throughput: one byte per cycle is sustained indefinitely when out_ready is tied to 1.
- Timeout (TIMEOUT>0):
  - The idle counter runs only in ASSEMBLE with byte_cnt!=0 and no accept this cycle.
  - It clears on any accept and whenever byte_cnt=0.
  - When the counter reaches TIMEOUT: byte_cnt<=0, assembly register cleared, err_timeout=1 for exactly one cycle, counter<=0.
  - An accept on the same edge as expiry wins: the byte is taken and no timeout occurs.
- No arithmetic beyond the counters.
- in_ready, byte_cnt and err_timeout are registered or derived only from state, with no combinational path from in8. in_ready may depend combinationally on out_ready only in HOLD; otherwise it is state-only.

Test Plan:
- Back-to-back words, out_ready=1, MSB_FIRST=1:
  - Bytes FF,FF,FF,FF then DD,DD,DD,DD then 00,00,00,03 -> out32 pulses one edge after each 4th byte.
  - out_data32 = FFFFFFFF, DDDDDDDD, 00000003 in that order.
  - in_ready stays 1 throughout.
- MSB_FIRST=0, bytes 11,22,33,44 -> out_data32=44332211.
- Backpressure:
  - out_ready=0, send 8 bytes 01..08 -> first word 01020304 on out32=1.
  - Second word completes and HOLD is entered; in_ready=0 and a 9th byte is not accepted.
  - Raise out_ready for 1 cycle -> out_data32=05060708, out32 stays 1, in_ready=1.
- Timeout, TIMEOUT=16:
  - Send AA,BB then idle -> byte_cnt=2 for 16 cycles, then err_timeout pulses once and byte_cnt=0.
  - Next bytes 01,02,03,04 -> 01020304.
- Reset mid-word:
  - Send 3 bytes, pull reset low asynchronously between edges -> out32=0, byte_cnt=0 immediately.
  - After release, 4 bytes CA,FE,BA,BE -> CAFEBABE.
- Gapped input: bytes 12,34,56,78 with 0-3 idle cycles of in8=0 between them (below TIMEOUT) -> 12345678, no err_timeout.

Source files
------------

// File: rtl/conv_8_32.sv
// Byte-to-word assembler: packs four accepted bytes into one 32-bit word behind a valid/ready output.
// Latency: one edge from the 4th accepted byte to out32 (or from out_ready when a word is held).
// Backpressure: one word is parked in the assembly register; in_ready drops only while that word waits.
module conv_8_32 #(
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 16,
    parameter int TO_W      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data8,
    input  logic        in8,
    output logic        in_ready,
    output logic [31:0] out_data32,
    output logic        out32,
    input  logic        out_ready,
    output logic [1:0]  byte_cnt,
    output logic        err_timeout
);

    typedef enum logic {ASSEMBLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [31:0]       asm_q, asm_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic              err_q, err_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_vld_q, out_vld_d;

    logic              accept;
    logic              word_done;
    logic [1:0]        lane;
    logic [31:0]       asm_word;

    assign accept    = in8 && in_ready;
    assign word_done = accept && (byte_cnt_q == 2'd3);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ASSEMBLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ASSEMBLE: if (word_done && out_vld_q && !out_ready) state_d = HOLD;
            HOLD:     if (out_ready) state_d = ASSEMBLE;
            default:  state_d = ASSEMBLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == ASSEMBLE);
    end

    // Byte lane for the current position, honouring the configured byte order.
    always_comb begin
        lane     = (MSB_FIRST != 0) ? (2'd3 - byte_cnt_q) : byte_cnt_q;
        asm_word = asm_q;
        asm_word[{lane, 3'b000} +: 8] = in_data8;
    end

    always_comb begin
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        idle_d     = idle_q;
        err_d      = 1'b0;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;

        if (out_ready) begin
            out_vld_d = 1'b0;
        end

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            idle_d     = '0;
            asm_d      = asm_word;
            if (word_done && (!out_vld_q || out_ready)) begin
                out_data_d = asm_word;
                out_vld_d  = 1'b1;
                asm_d      = '0;
            end
        end else if (state_q == HOLD) begin
            // The held word is always behind a valid output, so consume implies refill.
            if (out_ready) begin
                out_data_d = asm_q;
                out_vld_d  = 1'b1;
                asm_d      = '0;
            end
        end else if (byte_cnt_q == 2'd0) begin
            idle_d = '0;
        end else if (TIMEOUT > 0) begin
            if (idle_q == TO_W'(TIMEOUT - 1)) begin
                byte_cnt_d = 2'd0;
                asm_d      = '0;
                idle_d     = '0;
                err_d      = 1'b1;
            end else begin
                idle_d = idle_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q      <= '0;
            byte_cnt_q <= 2'd0;
            idle_q     <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign out_data32  = out_data_q;
    assign out32       = out_vld_q;
    assign byte_cnt    = byte_cnt_q;
    assign err_timeout = err_q;

endmodule
